// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache and D-cache miss FSMs.
// Define MEM_ARB_FIXED_DPRI_EN to make D win every tie (no round-robin pointer).
module mem_arbiter #(
  parameter int BURST_WORDS = 8,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fsm_busy,
  input  logic [15:0] i_addr,
  input  logic        d_fsm_busy,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_service,
  output logic        d_service,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [15:0] data_from_mem,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid
);

  typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DRAIN} state_t;

  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_WORDS);

  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] return_cnt;
  logic [CNT_W-1:0] return_next;
  logic             owner_busy;
  logic             d_req;
  logic             d_wins;

  assign d_req = d_fsm_busy | d_write;

`ifdef MEM_ARB_FIXED_DPRI_EN
  assign d_wins = d_req;
`else
  // last_d remembers who finished last so the other side wins the next tie
  logic last_d;
  assign d_wins = d_req & (~i_fsm_busy | ~last_d);
`endif

  assign owner_busy    = (state == D_FILL) ? d_fsm_busy : i_fsm_busy;
  assign return_next   = return_cnt + CNT_W'(mem_data_valid);
  assign data_from_mem = mem_data_out;
  assign i_data_valid  = (state == I_FILL) & mem_data_valid;
  assign d_data_valid  = (state == D_FILL) & mem_data_valid;

  always_comb begin
    i_service   = 1'b0;
    d_service   = 1'b0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    case (state)
      I_FILL: begin
        i_service  = 1'b1;
        mem_addr   = i_addr;
        mem_enable = i_fsm_busy & (issue_cnt < BURST_CNT);
      end
      D_FILL: begin
        d_service  = 1'b1;
        mem_addr   = d_addr;
        mem_enable = d_fsm_busy & (issue_cnt < BURST_CNT);
      end
      D_WRITE: begin
        d_service   = 1'b1;
        mem_addr    = d_addr;
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_data_in = d_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      return_cnt <= '0;
`ifndef MEM_ARB_FIXED_DPRI_EN
      last_d     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_wins)
            state <= d_write ? D_WRITE : D_FILL;
          else if (i_fsm_busy)
            state <= I_FILL;
        end
        I_FILL, D_FILL: begin
          // completion wins over a simultaneous busy drop: nothing is left in flight
          if (return_next == BURST_CNT) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            return_cnt <= '0;
`ifndef MEM_ARB_FIXED_DPRI_EN
            last_d     <= (state == D_FILL);
`endif
          end else begin
            if (mem_enable)
              issue_cnt <= issue_cnt + CNT_W'(1);
            return_cnt <= return_next;
            if (!owner_busy)
              state <= DRAIN;
          end
        end
        D_WRITE: begin
          state <= IDLE;
`ifndef MEM_ARB_FIXED_DPRI_EN
          last_d <= 1'b1;
`endif
        end
        DRAIN: begin
          if (return_next == issue_cnt) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            return_cnt <= '0;
          end else begin
            return_cnt <= return_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level
// reference model, with a fixed-latency pipelined memory and simple cache-side agents.
module tb_mem_arbiter;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fsm_busy, d_fsm_busy, d_write, mem_data_valid;
  logic [15:0] i_addr, d_addr, d_wdata, mem_data_out;
  logic        i_service, d_service, i_data_valid, d_data_valid, mem_enable, mem_wr;
  logic [15:0] data_from_mem, mem_addr, mem_data_in;

  mem_arbiter #(.BURST_WORDS(BW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_fsm_busy(i_fsm_busy), .i_addr(i_addr),
    .d_fsm_busy(d_fsm_busy), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_service(i_service), .d_service(d_service),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .data_from_mem(data_from_mem), .mem_addr(mem_addr), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // pipelined memory: a read accepted in cycle c returns in cycle c+lat
  bit          ret_v [64];
  logic [15:0] ret_d [64];
  int          cyc = 0;
  int          lat = 4;

  // reference model: who owns memory and how many beats are outstanding
  typedef enum {M_IDLE, M_IFILL, M_DFILL, M_DWRITE, M_DRAIN} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_issued = 0;
  int    m_returned = 0;
  bit    m_last_d = 1'b0;
  bit    exp_en;

  // cache-side agents and observation
  logic [15:0] i_base = '0, d_base = '0, d_waddr = '0;
  int  i_beats = 0, d_beats = 0, i_issued = 0, d_issued = 0, wr_cycles = 0;
  bit  saw_write = 1'b0, d_refill = 1'b0, rand_phase = 1'b0;
  bit  prev_i = 1'b0, prev_d = 1'b0, g_d_write = 1'b0;
  int  g_i_beats = 0, g_d_beats = 0;
  int  grant_log [$];

  function automatic bit d_wins_tie();
`ifdef MEM_ARB_FIXED_DPRI_EN
    return 1'b1;
`else
    return !m_last_d;
`endif
  endfunction

  task automatic compareCycle();
    bit          e_isv, e_dsv, e_wr, e_idv, e_ddv;
    logic [15:0] e_addr, e_wd;
    e_isv  = (m_mode == M_IFILL);
    e_dsv  = (m_mode == M_DFILL) || (m_mode == M_DWRITE);
    e_wr   = (m_mode == M_DWRITE);
    exp_en = 1'b0;
    e_addr = 16'h0000;
    if (m_mode == M_IFILL) begin
      e_addr = i_addr;
      exp_en = i_fsm_busy && (m_issued < BW);
    end else if (m_mode == M_DFILL) begin
      e_addr = d_addr;
      exp_en = d_fsm_busy && (m_issued < BW);
    end else if (m_mode == M_DWRITE) begin
      e_addr = d_addr;
      exp_en = 1'b1;
    end
    e_wd  = e_wr ? d_wdata : 16'h0000;
    e_idv = e_isv && mem_data_valid;
    e_ddv = (m_mode == M_DFILL) && mem_data_valid;
    checkOutput("i_service", i_service, e_isv);
    checkOutput("d_service", d_service, e_dsv);
    checkOutput("svc_exclusive", i_service & d_service, 0);
    checkOutput("mem_enable", mem_enable, exp_en);
    checkOutput("mem_wr", mem_wr, e_wr);
    checkOutput("mem_addr", mem_addr, e_addr);
    checkOutput("mem_data_in", mem_data_in, e_wd);
    checkOutput("i_data_valid", i_data_valid, e_idv);
    checkOutput("d_data_valid", d_data_valid, e_ddv);
    checkOutput("data_from_mem", data_from_mem, mem_data_out);
  endtask

  task automatic modelUpdate();
    bit d_req, owner_busy;
    d_req = d_fsm_busy || d_write;
    if (rst) begin
      m_mode = M_IDLE; m_issued = 0; m_returned = 0; m_last_d = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (d_req && i_fsm_busy)
            m_mode = d_wins_tie() ? (d_write ? M_DWRITE : M_DFILL) : M_IFILL;
          else if (d_req)
            m_mode = d_write ? M_DWRITE : M_DFILL;
          else if (i_fsm_busy)
            m_mode = M_IFILL;
        end
        M_IFILL, M_DFILL: begin
          owner_busy = (m_mode == M_IFILL) ? i_fsm_busy : d_fsm_busy;
          m_issued   += int'(exp_en);
          m_returned += int'(mem_data_valid);
          if (m_returned == BW) begin
            m_last_d = (m_mode == M_DFILL);
            m_mode = M_IDLE; m_issued = 0; m_returned = 0;
          end else if (!owner_busy) begin
            m_mode = M_DRAIN;
          end
        end
        M_DWRITE: begin
          m_mode = M_IDLE;
          m_last_d = 1'b1;
        end
        M_DRAIN: begin
          m_returned += int'(mem_data_valid);
          if (m_returned == m_issued) begin
            m_mode = M_IDLE; m_issued = 0; m_returned = 0;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic observe();
    if (i_data_valid) i_beats++;
    if (d_data_valid) d_beats++;
    if (i_service && mem_enable) i_issued++;
    if (d_service && mem_enable && !mem_wr) d_issued++;
    if (d_service && mem_wr) saw_write = 1'b1;
    if (mem_wr) wr_cycles++;
    if (i_service && !prev_i) begin grant_log.push_back(1); g_i_beats = 0; end
    if (d_service && !prev_d) begin grant_log.push_back(2); g_d_beats = 0; g_d_write = 1'b0; end
    if (i_service && i_data_valid) g_i_beats++;
    if (d_service && d_data_valid) g_d_beats++;
    if (d_service && mem_wr) g_d_write = 1'b1;
    if (rand_phase && prev_i && !i_service) checkOutput("i_grant_beats", g_i_beats, BW);
    if (rand_phase && prev_d && !d_service && !g_d_write) checkOutput("d_grant_beats", g_d_beats, BW);
    prev_i = i_service;
    prev_d = d_service;
  endtask

  // one clock cycle: memory drives, outputs checked mid-cycle, model steps, then the edge
  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    mem_data_valid = ret_v[cyc % 64];
    mem_data_out   = mem_data_valid ? ret_d[cyc % 64] : 16'($urandom);
    ret_v[cyc % 64] = 1'b0;
    #1;
    compareCycle();
    if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
      ret_v[(cyc + lat) % 64] = 1'b1;
      ret_d[(cyc + lat) % 64] = mem_addr ^ 16'hA5C3;
    end
    observe();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  // cache controllers: hold busy until 8 beats come back, hold d_write until it is taken
  task automatic runAgents(input bit allow_new);
    if (i_fsm_busy && i_beats >= BW)
      i_fsm_busy = 1'b0;
    else if (!i_fsm_busy && allow_new && $urandom_range(3) == 0) begin
      i_fsm_busy = 1'b1; i_base = 16'($urandom) & 16'hFFF0; i_beats = 0; i_issued = 0;
    end
    i_addr = i_base + 16'(2 * i_issued);
    if (d_write && saw_write) begin
      d_write = 1'b0; saw_write = 1'b0;
    end else if (d_fsm_busy && d_beats >= BW) begin
      if (d_refill) begin
        d_refill = 1'b0; d_beats = 0; d_issued = 0; d_base = d_base + 16'h0040;
      end else begin
        d_fsm_busy = 1'b0;
      end
    end else if (!d_fsm_busy && !d_write && allow_new && $urandom_range(3) == 0) begin
      if ($urandom_range(2) == 0) begin
        d_write = 1'b1; d_waddr = 16'($urandom); d_wdata = 16'($urandom); saw_write = 1'b0;
      end else begin
        d_fsm_busy = 1'b1; d_base = 16'($urandom) & 16'hFFF0; d_beats = 0; d_issued = 0;
      end
    end
    d_addr = d_write ? d_waddr : d_base + 16'(2 * d_issued);
  endtask

  initial begin
    int guard, waits, g0, g1, g2, e1, e2;
    rst = 1'b1; i_fsm_busy = 1'b0; d_fsm_busy = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_data_out = '0; mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // lone I fill at 0x0100.., 4-cycle memory
    i_base = 16'h0100; i_beats = 0; i_issued = 0; d_beats = 0; i_fsm_busy = 1'b1;
    runAgents(0); applyStimulus();
    checkOutput("i_grant_next_cycle", i_service, 1);
    checkOutput("i_first_addr", mem_addr, 16'h0100);
    guard = 0;
    while (i_fsm_busy && guard < 100) begin runAgents(0); applyStimulus(); guard++; end
    checkOutput("i_fill_timeout", guard < 100, 1);
    checkOutput("i_fill_beats", i_beats, BW);
    checkOutput("i_fill_no_d_valid", d_beats, 0);
    checkOutput("i_release", i_service, 0);

    // simultaneous requests; D re-requests right after its fill to create a second tie
    grant_log.delete();
    i_base = 16'h0200; d_base = 16'h0400; i_beats = 0; i_issued = 0; d_beats = 0; d_issued = 0;
    d_refill = 1'b1; i_fsm_busy = 1'b1; d_fsm_busy = 1'b1;
    guard = 0;
    while ((i_fsm_busy || d_fsm_busy) && guard < 200) begin runAgents(0); applyStimulus(); guard++; end
    checkOutput("tie_timeout", guard < 200, 1);
    checkOutput("tie_grant_count", grant_log.size(), 3);
    g0 = grant_log.size() > 0 ? grant_log[0] : 0;
    g1 = grant_log.size() > 1 ? grant_log[1] : 0;
    g2 = grant_log.size() > 2 ? grant_log[2] : 0;
`ifdef MEM_ARB_FIXED_DPRI_EN
    e1 = 2; e2 = 1;
`else
    e1 = 1; e2 = 2;
`endif
    checkOutput("tie_first_grant", g0, 2);
    checkOutput("tie_second_grant", g1, e1);
    checkOutput("tie_third_grant", g2, e2);

    // single-cycle D write
    wr_cycles = 0; d_waddr = 16'h2004; d_wdata = 16'hBEEF; saw_write = 1'b0; d_write = 1'b1;
    runAgents(0); applyStimulus();
    checkOutput("wr_d_service", d_service, 1);
    checkOutput("wr_mem_wr", mem_wr, 1);
    checkOutput("wr_mem_enable", mem_enable, 1);
    checkOutput("wr_mem_addr", mem_addr, 16'h2004);
    checkOutput("wr_mem_data_in", mem_data_in, 16'hBEEF);
    repeat (4) begin runAgents(0); applyStimulus(); end
    checkOutput("wr_one_cycle", wr_cycles, 1);
    checkOutput("wr_released", d_service, 0);

    // abort an I fill after 3 issued beats while D is waiting
    i_base = 16'h0300; i_beats = 0; i_issued = 0; i_fsm_busy = 1'b1;
    guard = 0;
    while (i_issued < 3 && guard < 50) begin runAgents(0); applyStimulus(); guard++; end
    checkOutput("abort_issue_timeout", guard < 50, 1);
    i_fsm_busy = 1'b0;
    d_base = 16'h0500; d_beats = 0; d_issued = 0; d_refill = 1'b0; d_fsm_busy = 1'b1;
    waits = 0;
    while (!d_service && waits < 40) begin runAgents(0); applyStimulus(); waits++; end
    checkOutput("abort_grant_delay", waits, 5);
    checkOutput("abort_no_i_valid", i_beats, 0);
    checkOutput("abort_no_d_valid", d_beats, 0);
    guard = 0;
    while (d_fsm_busy && guard < 100) begin runAgents(0); applyStimulus(); guard++; end
    checkOutput("abort_d_fill_beats", d_beats, BW);

    // reset in the middle of a D fill after 5 returned beats
    d_base = 16'h0600; d_beats = 0; d_issued = 0; d_fsm_busy = 1'b1;
    guard = 0;
    while (d_beats < 5 && guard < 60) begin runAgents(0); applyStimulus(); guard++; end
    checkOutput("rst_fill_timeout", guard < 60, 1);
    rst = 1'b1;
    runAgents(0); applyStimulus();
    rst = 1'b0; d_fsm_busy = 1'b0;
    checkOutput("rst_strobes", {i_service, d_service, mem_enable, mem_wr, i_data_valid, d_data_valid}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data_in", mem_data_in, 0);
    d_beats = 0; i_beats = 0;
    repeat (12) begin runAgents(0); applyStimulus(); end
    checkOutput("rst_late_valid_dropped", d_beats + i_beats, 0);

    // pointer was reset to I, so D must win this tie
    i_base = 16'h0700; d_base = 16'h0800; i_beats = 0; i_issued = 0; d_beats = 0; d_issued = 0;
    i_fsm_busy = 1'b1; d_fsm_busy = 1'b1;
    runAgents(0); applyStimulus();
    checkOutput("rst_pointer_tie", d_service, 1);
    guard = 0;
    while ((i_fsm_busy || d_fsm_busy) && guard < 200) begin runAgents(0); applyStimulus(); guard++; end
    checkOutput("rst_tie_timeout", guard < 200, 1);

    // random interleaved traffic
    lat = 2 + $urandom_range(3);
    rand_phase = 1'b1;
    repeat (2000) begin runAgents(1); applyStimulus(); end
    guard = 0;
    while ((i_fsm_busy || d_fsm_busy || d_write) && guard < 400) begin runAgents(0); applyStimulus(); guard++; end
    checkOutput("random_drain_timeout", guard < 400, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
